// File: rtl/pl_pkg.sv
// Shared definitions for the pipeline: widths, redirect encodings,
// bubble encoding and opcode constants used by the branch-resolution logic.
package pl_pkg;

    localparam int unsigned XLEN = 32;

    // Execute-stage redirect code. Bit 0 alone marks a taken redirect,
    // so the reserved code behaves exactly like sequential fetch.
    typedef enum logic [1:0] {
        PCSRC_SEQ  = 2'b00,
        PCSRC_BR   = 2'b01,
        PCSRC_RSVD = 2'b10,
        PCSRC_JMP  = 2'b11
    } pcsrc_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;

    // A redirect is taken whenever the low bit of the select code is set.
    function automatic logic is_redirect(input logic [1:0] pcsrc);
        return pcsrc[0];
    endfunction

endpackage

// File: rtl/pl_if_id_reg.sv
// IF/ID pipeline register. A flush loads a bubble (NOP, not valid, PC fields
// zeroed); otherwise a stall holds every field; otherwise the fetch-stage
// values are captured and marked valid. Flush has priority over stall.
module pl_if_id_reg #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic [31:0]        instr_f,
    input  logic [XLEN-1:0]    pc_f,
    input  logic [XLEN-1:0]    pc_plus4_f,
    output logic [31:0]        instr_d,
    output logic [XLEN-1:0]    pc_d,
    output logic [XLEN-1:0]    pc_plus4_d,
    output logic               valid_d
);

    logic [31:0]     instr_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_plus4_r;
    logic            valid_r;

    // Capture, hold or bubble the decode-stage instruction slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r    <= NOP_INSTR;
            pc_r       <= {XLEN{1'b0}};
            pc_plus4_r <= {XLEN{1'b0}};
            valid_r    <= 1'b0;
        end else if (flush) begin
            instr_r    <= NOP_INSTR;
            pc_r       <= {XLEN{1'b0}};
            pc_plus4_r <= {XLEN{1'b0}};
            valid_r    <= 1'b0;
        end else if (stall) begin
            instr_r    <= instr_r;
            pc_r       <= pc_r;
            pc_plus4_r <= pc_plus4_r;
            valid_r    <= valid_r;
        end else begin
            instr_r    <= instr_f;
            pc_r       <= pc_f;
            pc_plus4_r <= pc_plus4_f;
            valid_r    <= 1'b1;
        end
    end

    assign instr_d    = instr_r;
    assign pc_d       = pc_r;
    assign pc_plus4_d = pc_plus4_r;
    assign valid_d    = valid_r;

endmodule

// File: rtl/pl_fetch_stage.sv
// Fetch stage: owns the PC, picks the next PC from the execute-stage redirect
// code, addresses instruction memory and feeds the IF/ID register. A taken
// redirect squashes the wrong-path instruction already fetched. Also keeps a
// sticky misaligned-target flag and a saturating taken-redirect counter.
module pl_fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}},
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
    parameter int unsigned     CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic [1:0]         PCSrcE,
    input  logic [XLEN-1:0]    BranchTargetE,
    input  logic [XLEN-1:0]    JumpTargetE,
    input  logic [31:0]        InstrF,
    output logic [XLEN-1:0]    PCF,
    output logic [31:0]        InstrD,
    output logic [XLEN-1:0]    PCD,
    output logic [XLEN-1:0]    PCPlus4D,
    output logic               ValidD,
    output logic               MisalignErr,
    output logic [CNT_W-1:0]   RedirectCount
);

    import pl_pkg::*;

    logic [XLEN-1:0]  pc_r;
    logic [XLEN-1:0]  pc_plus4_s;
    logic [XLEN-1:0]  target_s;
    logic [XLEN-1:0]  next_pc_s;
    logic             redirect_s;
    logic             ifid_flush_s;
    logic             misalign_r;
    logic [CNT_W-1:0] redirect_cnt_r;

    // Next-PC selection: a taken redirect beats a fetch stall.
    always_comb begin
        redirect_s = is_redirect(PCSrcE);
        pc_plus4_s = pc_r + {{(XLEN-3){1'b0}}, 3'd4};
        target_s   = pc_plus4_s;
        case (pcsrc_e'(PCSrcE))
            PCSRC_BR:  target_s = BranchTargetE;
            // JALR targets may carry bit 0; it is always dropped here.
            PCSRC_JMP: target_s = {JumpTargetE[XLEN-1:1], 1'b0};
            default:   target_s = pc_plus4_s;
        endcase
        next_pc_s = pc_plus4_s;
        if (redirect_s) begin
            next_pc_s = target_s;
        end else if (StallF) begin
            next_pc_s = pc_r;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // Sticky flag: a taken redirect landed on a target with bit 1 set.
    // The PC is still loaded unchanged; only reset clears the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else if (redirect_s && target_s[1]) begin
            misalign_r <= 1'b1;
        end else begin
            misalign_r <= misalign_r;
        end
    end

    // Taken-redirect counter, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_r <= {CNT_W{1'b0}};
        end else if (redirect_s && !(&redirect_cnt_r)) begin
            redirect_cnt_r <= redirect_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            redirect_cnt_r <= redirect_cnt_r;
        end
    end

    // The instruction fetched alongside a taken redirect is on the wrong path.
    assign ifid_flush_s = FlushD | redirect_s;

    pl_if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (StallD),
        .flush      (ifid_flush_s),
        .instr_f    (InstrF),
        .pc_f       (pc_r),
        .pc_plus4_f (pc_plus4_s),
        .instr_d    (InstrD),
        .pc_d       (PCD),
        .pc_plus4_d (PCPlus4D),
        .valid_d    (ValidD)
    );

    assign PCF           = pc_r;
    assign MisalignErr   = misalign_r;
    assign RedirectCount = redirect_cnt_r;

endmodule

// File: tb/tb_pl_fetch_stage.sv
// Scoreboard bench for pl_fetch_stage: the stimulus process pushes the
// hand-computed post-edge state for every cycle, a monitor pops and compares
// on the falling edge. A second instance with CNT_W=2 shares the stimulus.
module tb_pl_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        StallF, StallD, FlushD;
    logic [1:0]  PCSrcE;
    logic [31:0] BranchTargetE, JumpTargetE;
    logic [31:0] InstrF, InstrF2;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD, MisalignErr;
    logic [15:0] RedirectCount;
    logic [31:0] PCF2, InstrD2, PCD2, PCPlus4D2;
    logic        ValidD2, MisalignErr2;
    logic [1:0]  RedirectCount2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        logic [31:0] pcf;
        logic [31:0] instrd;
        logic [31:0] pcd;
        logic [31:0] pcp4d;
        logic        validd;
        logic        mis;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t q[$];
    exp_t e;

    // Instruction memory model: data is a fixed pattern of the address.
    function automatic logic [31:0] imem(input logic [31:0] pc);
        return 32'hC0DE_0000 ^ pc;
    endfunction

    assign InstrF  = imem(PCF);
    assign InstrF2 = imem(PCF2);

    pl_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .BranchTargetE(BranchTargetE), .JumpTargetE(JumpTargetE),
        .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .MisalignErr(MisalignErr), .RedirectCount(RedirectCount)
    );

    pl_fetch_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .BranchTargetE(BranchTargetE), .JumpTargetE(JumpTargetE),
        .InstrF(InstrF2), .PCF(PCF2), .InstrD(InstrD2), .PCD(PCD2), .PCPlus4D(PCPlus4D2),
        .ValidD(ValidD2), .MisalignErr(MisalignErr2), .RedirectCount(RedirectCount2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exv);
        checks++;
        if (act !== exv) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exv);
        end
    endtask

    // Monitor: compare both instances against the oldest pending expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.nm, "PCF",           PCF,                   e.pcf);
            chk(e.nm, "InstrD",        InstrD,                e.instrd);
            chk(e.nm, "PCD",           PCD,                   e.pcd);
            chk(e.nm, "PCPlus4D",      PCPlus4D,              e.pcp4d);
            chk(e.nm, "ValidD",        {31'd0, ValidD},       {31'd0, e.validd});
            chk(e.nm, "MisalignErr",   {31'd0, MisalignErr},  {31'd0, e.mis});
            chk(e.nm, "RedirectCount", {16'd0, RedirectCount}, {16'd0, e.cnt});
            chk(e.nm, "PCF_w2",        PCF2,                  e.pcf);
            chk(e.nm, "InstrD_w2",     InstrD2,               e.instrd);
            chk(e.nm, "PCD_w2",        PCD2,                  e.pcd);
            chk(e.nm, "ValidD_w2",     {31'd0, ValidD2},      {31'd0, e.validd});
            chk(e.nm, "Misalign_w2",   {31'd0, MisalignErr2}, {31'd0, e.mis});
            chk(e.nm, "RedirCnt_w2",   {30'd0, RedirectCount2}, {30'd0, e.cnt2});
        end
    end

    // Build one expectation; IF/ID contents follow from the PC held in decode.
    task automatic push_exp(input string nm, input logic [31:0] pcf, input logic [31:0] pcd,
                            input logic v, input logic mis, input logic [15:0] cnt);
        exp_t x;
        x.nm     = nm;
        x.pcf    = pcf;
        x.pcd    = v ? pcd : 32'd0;
        x.instrd = v ? imem(pcd) : 32'h0000_0013;
        x.pcp4d  = v ? pcd + 32'd4 : 32'd0;
        x.validd = v;
        x.mis    = mis;
        x.cnt    = cnt;
        x.cnt2   = (cnt > 16'd3) ? 2'd3 : cnt[1:0];
        q.push_back(x);
    endtask

    task automatic cyc(input string nm, input logic [1:0] src, input logic [31:0] bt, input logic [31:0] jt,
                       input logic sf, input logic sd, input logic fd,
                       input logic [31:0] e_pcf, input logic [31:0] e_pcd, input logic e_v,
                       input logic e_mis, input logic [15:0] e_cnt);
        PCSrcE = src; BranchTargetE = bt; JumpTargetE = jt;
        StallF = sf; StallD = sd; FlushD = fd;
        @(posedge clk);
        push_exp(nm, e_pcf, e_pcd, e_v, e_mis, e_cnt);
        @(negedge clk);
    endtask

    task automatic idle(input string nm, input logic [31:0] e_pcf, input logic [31:0] e_pcd,
                        input logic e_mis, input logic [15:0] e_cnt);
        cyc(nm, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, e_pcf, e_pcd, 1'b1, e_mis, e_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 2'b00; BranchTargetE = 32'd0; JumpTargetE = 32'd0;
        @(posedge clk);
        push_exp("reset", 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Free run from reset.
        idle("run1", 32'h4,  32'h0, 1'b0, 16'd0);
        idle("run2", 32'h8,  32'h4, 1'b0, 16'd0);
        idle("run3", 32'hC,  32'h8, 1'b0, 16'd0);
        idle("run4", 32'h10, 32'hC, 1'b0, 16'd0);
        // Branch and jumps.
        cyc("branch", 2'b01, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 16'd1);
        idle("after_br", 32'h104, 32'h100, 1'b0, 16'd1);
        cyc("jalr_bit0", 2'b11, 32'h0, 32'h205, 1'b0, 1'b0, 1'b0, 32'h204, 32'h0, 1'b0, 1'b0, 16'd2);
        cyc("jmp_misal", 2'b11, 32'h0, 32'h206, 1'b0, 1'b0, 1'b0, 32'h206, 32'h0, 1'b0, 1'b1, 16'd3);
        idle("after_jmp", 32'h20A, 32'h206, 1'b1, 16'd3);
        // Full stall for three cycles.
        for (int i = 0; i < 3; i++) begin
            cyc("stall", 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h20A, 32'h206, 1'b1, 1'b1, 16'd3);
        end
        // Redirect beats StallF, and its squash beats StallD.
        cyc("redir_stall", 2'b01, 32'h300, 32'h0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b1, 16'd4);
        idle("run5", 32'h304, 32'h300, 1'b1, 16'd4);
        idle("run6", 32'h308, 32'h304, 1'b1, 16'd4);
        // Flush beats StallD.
        cyc("flush_stall", 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h30C, 32'h0, 1'b0, 1'b1, 16'd4);
        // Reserved code behaves as sequential, no count.
        cyc("rsvd", 2'b10, 32'h500, 32'h600, 1'b0, 1'b0, 1'b0, 32'h310, 32'h30C, 1'b1, 1'b1, 16'd4);
        cyc("stallD_only", 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h314, 32'h30C, 1'b1, 1'b1, 16'd4);
        cyc("stallF_only", 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h314, 32'h314, 1'b1, 1'b1, 16'd4);
        cyc("br_misal", 2'b01, 32'h402, 32'h0, 1'b0, 1'b0, 1'b0, 32'h402, 32'h0, 1'b0, 1'b1, 16'd5);
        // PC+4 wrap at the top of the address space.
        cyc("jmp_top", 2'b11, 32'h0, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1, 16'd6);
        idle("wrap", 32'h0, 32'hFFFF_FFFC, 1'b1, 16'd6);

        // Asynchronous reset mid-stream: checked before any further clock edge.
        PCSrcE = 2'b00; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        push_exp("async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        @(posedge clk);
        push_exp("rst_hold", 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle("rerun1", 32'h4, 32'h0, 1'b0, 16'd0);
        idle("rerun2", 32'h8, 32'h4, 1'b0, 16'd0);

        @(posedge clk);
        @(negedge clk);
        chk("scoreboard", "pending", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
